// File: rtl/dcm_lock_ctrl_if.sv
// Lock inputs and sequencing outputs of the clock-generator lock controller.
// master: the controller side; slave: the generators / system-reset consumers.
interface dcm_lock_ctrl_if;
    logic       LOCKED_40M;
    logic       LOCKED_100M;
    logic       DCM_RST;
    logic       SYS_RST;
    logic       FAIL;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;
    logic [2:0] STATE;

    modport master (
        input  LOCKED_40M, LOCKED_100M,
        output DCM_RST, SYS_RST, FAIL, RETRY_CNT, LOSS_CNT, STATE
    );

    modport slave (
        output LOCKED_40M, LOCKED_100M,
        input  DCM_RST, SYS_RST, FAIL, RETRY_CNT, LOSS_CNT, STATE
    );
endinterface

// File: rtl/dcm_lock_ctrl.sv
// Start-up / recovery sequencer for the 40 MHz and 100 MHz clock generators:
// pulses their reset, qualifies both locks, releases system reset, retries, faults.
module dcm_lock_ctrl #(
    parameter int DCM_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STABLE_CYC   = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic           CLK_50M,
    input  logic           RST_N,
    dcm_lock_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_DCMRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    logic [1:0]       sync_40;
    logic [1:0]       sync_100;
    logic             both_lock;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             retry_req;
    logic             loss_evt;

    logic             dcm_rst_q;
    logic             sys_rst_q;
    logic             fail_q;
    logic [3:0]       retry_cnt_q;
    logic [7:0]       loss_cnt_q;

    // Two-flop synchronisers for the asynchronous lock indications.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync_40  <= '0;
            sync_100 <= '0;
        end else begin
            // NOTE: non-blocking so both stages sample the previous edge's values.
            sync_40  <= {sync_40[0], bus.LOCKED_40M};
            sync_100 <= {sync_100[0], bus.LOCKED_100M};
        end
    end

    assign both_lock = sync_40[1] & sync_100[1];

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_nxt = state_q;
        retry_req = 1'b0;
        loss_evt  = 1'b0;
        case (state_q)
            S_DCMRST: if (cnt_q == DCM_LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                // A lock seen on the timeout cycle still wins over the retry.
                if (both_lock)                state_nxt = S_STABLE;
                else if (cnt_q == WAIT_LAST)  retry_req = 1'b1;
            end
            S_STABLE: begin
                if (!both_lock)                 state_nxt = S_WAIT;
                else if (cnt_q == STABLE_LAST)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!both_lock) begin
                    loss_evt  = 1'b1;
                    retry_req = 1'b1;
                end
            end
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_DCMRST;
        endcase
        if (retry_req)
            state_nxt = (retry_cnt_q == RETRY_MAX) ? S_FAIL : S_DCMRST;
    end

    // Outputs are decoded from the next state so they update on the same edge as the state.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_DCMRST;
            cnt_q       <= '0;
            dcm_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            fail_q      <= 1'b0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= (state_nxt != state_q) ? '0 : cnt_q + 1'b1;
            dcm_rst_q <= (state_nxt == S_DCMRST) || (state_nxt == S_FAIL);
            sys_rst_q <= (state_nxt != S_RUN);
            fail_q    <= fail_q | (state_nxt == S_FAIL);

            if (state_nxt == S_RUN && state_q != S_RUN)
                retry_cnt_q <= '0;
            else if (retry_req && retry_cnt_q != RETRY_MAX)
                retry_cnt_q <= retry_cnt_q + 4'd1;

            if (loss_evt && loss_cnt_q != 8'hFF)
                loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign bus.DCM_RST   = dcm_rst_q;
    assign bus.SYS_RST   = sys_rst_q;
    assign bus.FAIL      = fail_q;
    assign bus.RETRY_CNT = retry_cnt_q;
    assign bus.LOSS_CNT  = loss_cnt_q;
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Scoreboard bench for dcm_lock_ctrl: stimulus queues expected state transitions,
// a negedge monitor pops and compares them whenever STATE changes or reset is applied.
module tb_dcm_lock_ctrl;

    localparam logic [2:0] ST_DCMRST = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    typedef struct {
        logic       is_reset;
        int         edge_no;
        logic [2:0] state;
        logic       dcm;
        logic       sys;
        logic       fail;
        logic [3:0] retry;
        logic [7:0] loss;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t       sb[$];
    exp_t       e;
    logic [2:0] prev_state = 3'd0;
    logic       rst_checked = 1'b0;

    dcm_lock_ctrl_if bus ();

    dcm_lock_ctrl #(
        .DCM_RST_CYC (4),
        .LOCK_TIMEOUT(20),
        .STABLE_CYC  (8),
        .MAX_RETRY   (2)
    ) dut (
        .CLK_50M(clk),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    // Edge numbering restarts at 1 on the first rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n = 0;
        else        edge_n = edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors = vectors + 1;
        if (act !== exp_v) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic exp_tr(input int edge_no, input logic [2:0] state, input logic dcm,
                          input logic sys, input logic fail, input logic [3:0] retry,
                          input logic [7:0] loss);
        exp_t x;
        x.is_reset = 1'b0;
        x.edge_no  = edge_no;
        x.state    = state;
        x.dcm      = dcm;
        x.sys      = sys;
        x.fail     = fail;
        x.retry    = retry;
        x.loss     = loss;
        sb.push_back(x);
    endtask

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 5000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (edge_n < n) flag($sformatf("timeout waiting for edge %0d", n));
    endtask

    // Asserts reset (asynchronously, mid-cycle), queues the reset-value expectation, releases.
    task automatic do_reset(input logic l40, input logic l100);
        exp_t x;
        x.is_reset = 1'b1;
        x.edge_no  = 0;
        x.state    = ST_DCMRST;
        x.dcm      = 1'b1;
        x.sys      = 1'b1;
        x.fail     = 1'b0;
        x.retry    = 4'd0;
        x.loss     = 8'd0;
        sb.push_back(x);
        rst_n = 1'b0;
        bus.LOCKED_40M  = l40;
        bus.LOCKED_100M = l100;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drained(input string name);
        check({name, " pending expectations"}, sb.size(), 0);
    endtask

    // Monitor: reset values on the first negedge of each reset pulse, else on every STATE change.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (!rst_checked) begin
                rst_checked = 1'b1;
                if (sb.size() == 0 || !sb[0].is_reset) begin
                    flag("reset applied with no reset expectation queued");
                end else begin
                    e = sb.pop_front();
                    check("reset STATE",     bus.STATE,     e.state);
                    check("reset DCM_RST",   bus.DCM_RST,   e.dcm);
                    check("reset SYS_RST",   bus.SYS_RST,   e.sys);
                    check("reset FAIL",      bus.FAIL,      e.fail);
                    check("reset RETRY_CNT", bus.RETRY_CNT, e.retry);
                    check("reset LOSS_CNT",  bus.LOSS_CNT,  e.loss);
                end
            end
            prev_state = 3'd0;
        end else begin
            rst_checked = 1'b0;
            if (bus.STATE !== prev_state) begin
                if (sb.size() == 0 || sb[0].is_reset) begin
                    flag($sformatf("unexpected transition %0d->%0d at edge %0d",
                                   prev_state, bus.STATE, edge_n));
                end else begin
                    e = sb.pop_front();
                    check($sformatf("edge of transition to %0d", e.state), edge_n, e.edge_no);
                    check($sformatf("e%0d STATE", e.edge_no),     bus.STATE,     e.state);
                    check($sformatf("e%0d DCM_RST", e.edge_no),   bus.DCM_RST,   e.dcm);
                    check($sformatf("e%0d SYS_RST", e.edge_no),   bus.SYS_RST,   e.sys);
                    check($sformatf("e%0d FAIL", e.edge_no),      bus.FAIL,      e.fail);
                    check($sformatf("e%0d RETRY_CNT", e.edge_no), bus.RETRY_CNT, e.retry);
                    check($sformatf("e%0d LOSS_CNT", e.edge_no),  bus.LOSS_CNT,  e.loss);
                end
                prev_state = bus.STATE;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.LOCKED_40M  = 1'b1;
        bus.LOCKED_100M = 1'b1;

        // Cold start with locks held high.
        do_reset(1'b1, 1'b1);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(5,  ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(13, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        wait_edge(20);
        drained("cold start");

        // Locks never rise: two retries, then fault at edge 72.
        do_reset(1'b0, 1'b0);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(24, ST_DCMRST, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0);
        exp_tr(28, ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd1, 8'd0);
        exp_tr(48, ST_DCMRST, 1'b1, 1'b1, 1'b0, 4'd2, 8'd0);
        exp_tr(52, ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd2, 8'd0);
        exp_tr(72, ST_FAIL,   1'b1, 1'b1, 1'b1, 4'd2, 8'd0);
        wait_edge(80);
        drained("no lock");

        // Reset pulsed in S_FAIL, then cold start repeats.
        do_reset(1'b1, 1'b1);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(5,  ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(13, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        wait_edge(16);
        drained("restart after fail");

        // 3-cycle lock drop during S_STABLE, then a lock loss in S_RUN.
        do_reset(1'b1, 1'b1);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(5,  ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(10, ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(13, ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(21, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        exp_tr(28, ST_DCMRST, 1'b1, 1'b1, 1'b0, 4'd1, 8'd1);
        exp_tr(32, ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd1, 8'd1);
        exp_tr(33, ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1);
        exp_tr(41, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd1);
        wait_edge(7);
        bus.LOCKED_100M = 1'b0;
        wait_edge(10);
        bus.LOCKED_100M = 1'b1;
        wait_edge(25);
        bus.LOCKED_40M = 1'b0;
        wait_edge(29);
        bus.LOCKED_40M = 1'b1;
        wait_edge(48);
        drained("stable glitch and run loss");

        // Lock becomes visible exactly on the WAIT timeout cycle.
        do_reset(1'b0, 1'b0);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(24, ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(32, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        wait_edge(21);
        bus.LOCKED_40M  = 1'b1;
        bus.LOCKED_100M = 1'b1;
        wait_edge(40);
        drained("lock vs timeout");

        // Reset pulsed mid-S_STABLE, then cold start repeats.
        do_reset(1'b1, 1'b1);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(5,  ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        wait_edge(8);
        drained("pre mid-stable reset");
        do_reset(1'b1, 1'b1);
        exp_tr(4,  ST_WAIT,   1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(5,  ST_STABLE, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
        exp_tr(13, ST_RUN,    1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        wait_edge(20);
        drained("restart after mid-stable reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcm_lock_ctrl.md
# dcm_lock_ctrl

Sequences start-up and recovery of the two clock generators (40 MHz and 100 MHz synthesisers) in the clock/reset subsystem. It drives the generators' shared reset and monitors both lock indications. It holds the system reset asserted until both have been continuously locked for a qualification window. On lock loss or lock timeout it retries the generators, and after a bounded number of failed retries it latches a fault.

## Interface

Parameters:
- DCM_RST_CYC, 16: cycles DCM_RST is held high per attempt (must be ≥ 2).
- LOCK_TIMEOUT, 65535: cycles allowed in S_WAIT for both locks before a retry (≤ 2^20).
- STABLE_CYC, 1024: cycles both locks must stay high before SYS_RST release (≤ 2^20).
- MAX_RETRY, 3: retries allowed before fault (1..15).

Ports:
- CLK_50M, in, 1: free-running 50 MHz reference clock; the only clock.
- RST_N, in, 1: asynchronous, active-low reset.
- LOCKED_40M, in, 1: lock from the 40 MHz generator; asynchronous, double-flop synchronised internally.
- LOCKED_100M, in, 1: lock from the 100 MHz generator; asynchronous, double-flop synchronised.
- DCM_RST, out, 1: reset to both generators, high-active.
- SYS_RST, out, 1: system reset, high-active.
- FAIL, out, 1: sticky fault flag.
- RETRY_CNT, out, 4: retries used since the last entry to S_RUN.
- LOSS_CNT, out, 8: saturating count of lock-loss events seen in S_RUN.
- STATE, out, 3: current state encoding, for debug.

## Operation

- both_lock = sync(LOCKED_40M) & sync(LOCKED_100M). Sync flops reset to 0. One 20-bit cycle counter is cleared on every state change.
- Reset values (RST_N low): state S_DCMRST (0), counter 0, DCM_RST 1, SYS_RST 1, FAIL 0, RETRY_CNT 0, LOSS_CNT 0, STATE 0.
- S_DCMRST (0): DCM_RST=1, SYS_RST=1. When counter = DCM_RST_CYC-1, go to S_WAIT.
- S_WAIT (1): DCM_RST=0, SYS_RST=1.
  - If both_lock, go to S_STABLE.
  - Else if counter = LOCK_TIMEOUT-1, take the retry path.
  - If lock and timeout occur in the same cycle, lock wins.
- S_STABLE (2): SYS_RST=1.
  - If both_lock drops, go back to S_WAIT. No retry is consumed and the counter restarts.
  - When counter = STABLE_CYC-1 with both_lock high, go to S_RUN.
- S_RUN (3): SYS_RST=0, and RETRY_CNT is cleared on entry.
  - If both_lock drops, LOSS_CNT increments (saturating at 255) and the retry path is taken.
- Retry path:
  - If RETRY_CNT = MAX_RETRY, go to S_FAIL.
  - Otherwise increment RETRY_CNT and go to S_DCMRST.
- S_FAIL (4): DCM_RST=1, SYS_RST=1, FAIL=1. Terminal; only RST_N exits this state.
- Encodings 5–7 are illegal and recover to S_DCMRST on the next cycle.

## Timing

- All outputs are registered and change on the same edge as the state register, so they cannot glitch.
- Lock input to both_lock latency is 2 cycles. A lock drop in S_RUN therefore asserts SYS_RST on the 3rd edge after the drop.
- Cold start with both locks high from reset: DCM_RST is high for edges 1..DCM_RST_CYC. S_WAIT lasts 1 cycle. SYS_RST falls at edge DCM_RST_CYC+1+STABLE_CYC.
- Asynchronous reset assertion at any point, including mid-retry or in S_FAIL, forces the reset values immediately. Deassertion is applied through the normal clock edge.
- A single-cycle lock glitch in S_STABLE restarts qualification. The same glitch in S_RUN triggers a full retry.

## Test plan

Parameters for all tests: DCM_RST_CYC=4, LOCK_TIMEOUT=20, STABLE_CYC=8, MAX_RETRY=2.

- Cold start, locks held high: DCM_RST high for edges 1–4; SYS_RST falls at edge 13; RETRY_CNT=0, FAIL=0.
- Locks never rise: sequence is DCMRST(4) → WAIT(20), repeated 3 times; RETRY_CNT counts 1, then 2; FAIL=1 and STATE=4 at edge 72; DCM_RST and SYS_RST stay 1.
- Lock drops for 3 cycles during S_STABLE: return to S_WAIT; RETRY_CNT unchanged; SYS_RST falls 8 cycles after the re-lock is seen.
- Lock loss in S_RUN: SYS_RST=1 on the 3rd edge after the drop; LOSS_CNT=1; RETRY_CNT=1; after re-lock, RUN is re-entered and RETRY_CNT=0.
- Lock and timeout coincide: both_lock rises at WAIT counter=19; next state is S_STABLE, RETRY_CNT is unchanged.
- RST_N pulsed low in S_FAIL and mid-S_STABLE: all outputs return to reset values asynchronously, and the cold-start sequence repeats.
